// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key schedule (AES-128/192/256 chosen per run by klen).
// Expands one 32-bit word per cycle from a sliding window of the last NK
// words. Each 128-bit round key is offered on a valid/ready stream, and the
// stream stalls under backpressure.
// Optional build macro KEYSCHED_STORE_EN: each accepted round key is also
// kept in a 15-entry array that can be read through rd_idx/rd_key.

// Combinational SubWord: computes the S-box as the GF(2^8) inverse followed
// by the affine transform.
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse is a^254. 254 = 2+4+...+128, so multiply together the
  // successive squares of a.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

module aes_key_schedule_seq #(
  parameter int NK_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   klen,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {S_IDLE, S_GEN, S_HOLD} state_t;

  state_t       state_q;
  logic [31:0]  win_q [NK_MAX];
  logic [31:0]  win_d [NK_MAX];
  logic [3:0]   nk_q;
  logic [2:0]   phase_q;      // i % NK
  logic [5:0]   cnt_q;        // word index i
  logic [5:0]   last_cnt_q;   // 4*(NR+1)-1 for this run
  logic [7:0]   rcon_q;
  logic [127:0] rk_q;
  logic [3:0]   rk_idx_q;
  logic         rk_valid_q, rk_last_q, busy_q, err_q, done_q;

  logic [3:0]   nk_sel;
  logic [5:0]   last_sel;
  logic         legal;
  logic         hs, word_we, is_last_word, key_phase;
  logic [31:0]  prev_word, sub_in, sub_out, new_word;

  // Key words beyond NK_MAX never enter the window.
  logic key_tail_unused;
  assign key_tail_unused = ^key_in;

  // Decode klen into the key length in words and the final word index.
  always_comb begin
    // NOTE: each always_comb output gets a default first so that no path infers a latch.
    nk_sel   = 4'd0;
    last_sel = 6'd0;
    case (klen)
      2'd0:    begin nk_sel = 4'd4; last_sel = 6'd43; end
      2'd1:    begin nk_sel = 4'd6; last_sel = 6'd51; end
      2'd2:    begin nk_sel = 4'd8; last_sel = 6'd59; end
      default: ;
    endcase
    legal = (nk_sel != 4'd0) && (int'(nk_sel) <= NK_MAX);
  end

  assign hs           = rk_valid_q && rk_ready;
  // A handshake that is not the last one also writes the next word.
  assign word_we      = (state_q == S_GEN) || (hs && !rk_last_q);
  assign is_last_word = (cnt_q == last_cnt_q);
  assign key_phase    = (cnt_q < {2'b00, nk_q});

  // w[i-1] is the newest window entry, held at slot NK-1.
  always_comb begin
    prev_word = win_q[0];
    for (int j = 0; j < NK_MAX; j++)
      if (j == int'(nk_q) - 1) prev_word = win_q[j];
  end

  assign sub_in = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Word rule. Slot 0 holds w[i-NK]. While i < NK the loaded key words
  // rotate through the window unchanged.
  always_comb begin
    if (key_phase)                             new_word = win_q[0];
    else if (phase_q == 3'd0)                  new_word = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && phase_q == 3'd4)  new_word = win_q[0] ^ sub_out;
    else                                       new_word = win_q[0] ^ prev_word;
  end

  // Shift the window down by one and append the new word at slot NK-1.
  always_comb begin
    for (int j = 0; j < NK_MAX - 1; j++) win_d[j] = win_q[j + 1];
    win_d[NK_MAX - 1] = new_word;
    for (int j = 0; j < NK_MAX; j++)
      if (j == int'(nk_q) - 1) win_d[j] = new_word;
  end

  // Control FSM, word generation and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int j = 0; j < NK_MAX; j++) win_q[j] <= '0;
      nk_q       <= 4'd4;
      phase_q    <= 3'd0;
      cnt_q      <= 6'd0;
      last_cnt_q <= 6'd0;
      rcon_q     <= 8'h01;
      rk_q       <= '0;
      rk_idx_q   <= 4'd0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register here sees pre-edge values.
      err_q  <= 1'b0;
      done_q <= 1'b0;
      if (word_we) begin
        win_q   <= win_d;
        cnt_q   <= is_last_word ? cnt_q : cnt_q + 6'd1;
        phase_q <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0 && !key_phase)
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        case (cnt_q[1:0])
          2'd0: rk_q[127:96] <= new_word;
          2'd1: rk_q[95:64]  <= new_word;
          2'd2: rk_q[63:32]  <= new_word;
          2'd3: rk_q[31:0]   <= new_word;
        endcase
      end
      case (state_q)
        S_IDLE: if (start) begin
          if (legal) begin
            for (int j = 0; j < NK_MAX; j++) win_q[j] <= key_in[255 - 32*j -: 32];
            nk_q       <= nk_sel;
            last_cnt_q <= last_sel;
            cnt_q      <= 6'd0;
            phase_q    <= 3'd0;
            rcon_q     <= 8'h01;
            busy_q     <= 1'b1;
            state_q    <= S_GEN;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_GEN: if (cnt_q[1:0] == 2'd3) begin
          state_q    <= S_HOLD;
          rk_valid_q <= 1'b1;
          rk_idx_q   <= cnt_q[5:2];
          rk_last_q  <= is_last_word;
        end
        S_HOLD: if (rk_ready) begin
          rk_valid_q <= 1'b0;
          rk_last_q  <= 1'b0;
          if (rk_last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_GEN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;
  assign done     = done_q;

`ifdef KEYSCHED_STORE_EN
  logic [127:0] store_q [15];
  logic [14:0]  store_vld_q;
  logic         store_done_q;

  // Capture each accepted round key at its index.
  // NOTE: the key array itself is never reset; the valid mask alone decides what reads back.
  always_ff @(posedge clk) begin
    if (hs)
      for (int j = 0; j < 15; j++)
        if (rk_idx_q == 4'(j)) store_q[j] <= rk_q;
  end

  // Entry-valid mask and completed-run flag, cleared on reset and on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_vld_q  <= '0;
      store_done_q <= 1'b0;
    end else if (state_q == S_IDLE && start && legal) begin
      store_vld_q  <= '0;
      store_done_q <= 1'b0;
    end else if (hs) begin
      for (int j = 0; j < 15; j++)
        if (rk_idx_q == 4'(j)) store_vld_q[j] <= 1'b1;
      if (rk_last_q) store_done_q <= 1'b1;
    end
  end

  // Combinational read port. Entries that are unwritten or out of range read as zero.
  always_comb begin
    rd_key = '0;
    for (int j = 0; j < 15; j++)
      if (store_done_q && store_vld_q[j] && rd_idx == 4'(j)) rd_key = store_q[j];
  end
`else
  logic rd_idx_unused;
  assign rd_idx_unused = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Testbench for aes_key_schedule_seq. A FIPS-197 reference model uses a
// tabulated S-box and modulo arithmetic. Stimulus covers the standard
// vectors, random keys, random backpressure, an illegal klen, an NK_MAX=4
// instance and a reset in the middle of a run.
module tb_aes_key_schedule_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, start4, rk_ready;
  logic [1:0]   klen;
  logic [255:0] key_in;
  logic [3:0]   rd_idx;
  logic         busy, err, rk_valid, rk_last, done;
  logic [127:0] rk, rd_key;
  logic [3:0]   rk_idx;
  logic         busy4, err4, rk_valid4, rk_last4, done4;
  logic [127:0] rk4, rd_key4;
  logic [3:0]   rk_idx4;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_rk [15];
  logic [127:0] got    [15];

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_schedule_seq #(.NK_MAX(8)) dut (
    .clk(clk), .reset(reset), .start(start), .klen(klen), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_idx(rk_idx), .rk_last(rk_last), .done(done), .rd_idx(rd_idx), .rd_key(rd_key));

  aes_key_schedule_seq #(.NK_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .klen(klen), .key_in(key_in),
    .busy(busy4), .err(err4), .rk_valid(rk_valid4), .rk_ready(rk_ready), .rk(rk4),
    .rk_idx(rk_idx4), .rk_last(rk_last4), .done(done4), .rd_idx(rd_idx), .rd_key(rd_key4));

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[127 - 8*int'(b[3:0]) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Full FIPS-197 expansion into exp_rk[0..NR].
  task automatic build_model(input int kl, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    nk = 4 + 2*kl;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0)                t = sub_word(rot_word(t)) ^ {RCON[i/nk - 1], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = '0;
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full expansion. ready_pct=100 also checks the exact output cadence.
  task automatic run_key(input int kl, input logic [255:0] key, input int ready_pct, input bit poke);
    int nr, n, k;
    bit fin;
    build_model(kl, key);
    nr = 10 + 2*kl;
    for (int r = 0; r < 15; r++) got[r] = '0;
    klen = 2'(kl); key_in = key; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0; key_in = rand256(); klen = 2'($urandom_range(0, 3));
    check("busy_after_start", 128'(busy), 128'(1));
    n = 0; k = 0; fin = 1'b0;
    while (!fin && n < 1500) begin
      tick();
      n++;
      if (done === 1'b1) begin
        fin = 1'b1;
        check("handshake_count", 128'(k), 128'(nr + 1));
        if (ready_pct >= 100) check("done_latency", 128'(n), 128'(4*nr + 5));
        check("busy_at_done", 128'(busy), 128'(0));
        check("valid_at_done", 128'(rk_valid), 128'(0));
      end else begin
        check("busy_run", 128'(busy), 128'(1));
        check("err_run", 128'(err), 128'(0));
        if (ready_pct >= 100) check("valid_cadence", 128'(rk_valid), 128'(n % 4 == 0));
        if (rk_valid === 1'b1) begin
          if (k <= nr) begin
            check("rk", rk, exp_rk[k]);
            check("rk_idx", 128'(rk_idx), 128'(k));
            check("rk_last", 128'(rk_last), 128'(k == nr));
            got[k] = rk;
          end else begin
            check("extra_key", 128'(k), 128'(nr));
          end
        end
        rk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (rk_valid === 1'b1 && rk_ready) k++;
        if (poke) begin
          start = (n == 9);
          if (n == 9) klen = 2'd3;
        end
      end
    end
    start = 1'b0;
    if (!fin) check("run_timeout", 128'(0), 128'(1));
    rk_ready = 1'b0;
    tick();
    check("done_pulse_end", 128'(done), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_valid", 128'(rk_valid), 128'(0));
  endtask

  initial begin
    logic [255:0] key;
    bit found;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; rk_ready = 1'b0;
    klen = 2'd0; key_in = '0; rd_idx = 4'd0;
    tick();
    tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_valid", 128'(rk_valid), 128'(0));
    check("rst_last", 128'(rk_last), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_rk", rk, 128'(0));
    check("rst_idx", 128'(rk_idx), 128'(0));
    check("rst_rd_key", rd_key, 128'(0));
    check("rst4_outs", 128'({busy4, err4, rk_valid4, rk_last4, done4, rk_idx4}), 128'(0));
    check("rst4_rk", rk4 | rd_key4, 128'(0));
    reset = 1'b0;
    tick();
    check("idle_no_start", 128'({busy, rk_valid, err}), 128'(0));

    // Standard vectors with full-rate consumer
    run_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 100, 1'b0);
    check("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 100, 1'b1);
    check("aes192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("aes192_last_word", 128'(got[12][31:0]), 128'h01002202);
    run_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 100, 1'b0);
    check("aes256_w8", 128'(got[2][127:96]), 128'h9ba35411);
    check("aes256_w12", 128'(got[3][127:96]), 128'ha8b09c1a);
    check("aes256_last_word", 128'(got[14][31:0]), 128'h706c631e);

    // Random keys under random backpressure
    for (int t = 0; t < 3; t++) run_key(t, rand256(), 50, 1'b0);
    for (int t = 0; t < 3; t++) run_key(t, rand256(), 100, 1'b0);
    run_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 30, 1'b0);
    check("stall_aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Stored-key read port
    rd_idx = 4'd10;
    #1;
`ifdef KEYSCHED_STORE_EN
    check("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
    check("store_rd10", rd_key, 128'(0));
`endif
    rd_idx = 4'd12;
    #1;
    check("store_rd12", rd_key, 128'(0));
    rd_idx = 4'd0;

    // Reserved klen
    klen = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("klen3_err", 128'(err), 128'(1));
    check("klen3_busy", 128'(busy), 128'(0));
    tick();
    check("klen3_err_pulse", 128'(err), 128'(0));
    check("klen3_idle", 128'({busy, rk_valid}), 128'(0));

    // NK above NK_MAX
    klen = 2'd2; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("nkmax_err", 128'(err4), 128'(1));
    check("nkmax_busy", 128'(busy4), 128'(0));
    tick();
    check("nkmax_err_pulse", 128'(err4), 128'(0));
    klen = 2'd0; key_in = rand256(); start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("nkmax_legal_busy", 128'(busy4), 128'(1));
    check("nkmax_legal_err", 128'(err4), 128'(0));

    // Reset in the middle of a run
    key = rand256();
    build_model(0, key);
    klen = 2'd0; key_in = key; start = 1'b1;
    tick();
    start = 1'b0; rk_ready = 1'b1; found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (rk_valid === 1'b1 && rk_idx === 4'd5) found = 1'b1;
    end
    check("midrst_reach_idx5", 128'(found), 128'(1));
    check("midrst_rk5", rk, exp_rk[5]);
    reset = 1'b1; rk_ready = 1'b0;
    tick();
    check("midrst_flags", 128'({busy, err, rk_valid, rk_last, done}), 128'(0));
    check("midrst_rk", rk, 128'(0));
    check("midrst_idx", 128'(rk_idx), 128'(0));
    check("midrst4_flags", 128'({busy4, err4, rk_valid4, done4}), 128'(0));
    reset = 1'b0;
    tick();
    run_key(1, rand256(), 70, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
